// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 device-to-host receiver feeding the keyboard inputs
// (kdone/kdata/kerr) of the I/O block. Synchronises both pins, de-glitches
// the clock, deserialises 11-bit frames and strobes each scan-code byte.
// Optional feature macro: PS2_PARITY_CHECK_EN (reject frames with bad odd parity).
module ps2_keyboard #(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       kdone,
  output logic [7:0] kdata,
  output logic       kerr
);

  localparam int               TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [3:0]       FILT_LAST = 4'(FILTER - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic             clk_p0, clk_p1;
  logic             data_p0, data_p1;
  logic             filt_clk;
  logic [3:0]       filt_cnt;
  logic             fall_p2;
  logic [1:0]       state;
  logic [7:0]       shift_reg;
  logic [3:0]       bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             parity_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign parity_ok = ^{shift_reg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Stage p0/p1: two-flop synchronisers for the asynchronous pins (idle level 1).
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
      data_p0 <= 1'b1;
      data_p1 <= 1'b1;
    end else begin
      clk_p0  <= ps2_clk;
      clk_p1  <= clk_p0;
      data_p0 <= ps2_data;
      data_p1 <= data_p0;
    end
  end

  // Stage p2: clock filter; level flips after FILTER consecutive differing samples,
  // and a 1->0 flip raises the one-cycle falling-edge strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall_p2  <= 1'b0;
    end else begin
      fall_p2 <= 1'b0;
      if (clk_p1 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_p1;
        filt_cnt <= '0;
        fall_p2  <= ~clk_p1;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  // Frame FSM plus inter-edge timeout; a falling edge beats a simultaneous timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      kdone     <= 1'b0;
      kdata     <= 8'h00;
      kerr      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      kdone <= 1'b0;
      kerr  <= 1'b0;
      if (fall_p2) begin
        tmo_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!data_p1) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shift_reg <= {data_p1, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              state <= S_PARITY;
            end
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= data_p1;
`endif
            state <= S_STOP;
          end
          S_STOP: begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            if (data_p1 && parity_ok) begin
              kdone <= 1'b1;
              kdata <= shift_reg;
            end else begin
              kerr <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end else if (state == S_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_MAX) begin
        kerr    <= 1'b1;
        state   <= S_IDLE;
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed bench for ps2_keyboard with an expected-strobe
// scoreboard. Frames are bit-banged on the pins; a monitor pops the queue on
// every kdone/kerr strobe.
`timescale 1ns/1ps
module tb_ps2_keyboard;

  localparam int FILTER    = 4;
  localparam int TIMEOUT   = 25000;
  localparam int HALF_SLOW = 1000;  // 80 us PS/2 clock period at 25 MHz
  localparam int HALF_FAST = 20;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       kdone;
  logic [7:0] kdata;
  logic       kerr;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         stop_cyc = 0;
  logic [7:0] model_kdata = 8'h00;

  ps2_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kdone   (kdone),
    .kdata   (kdata),
    .kerr    (kerr)
  );

  // 25 MHz system clock.
  always #20 clock = ~clock;

  // Cycle counter used for the stop-edge to kdone latency check.
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (kdone || kerr)) begin
      tests++;
      assert (!(kdone && kerr)) else begin
        fails++;
        $error("FAIL both_strobes kdone=%0b kerr=%0b required at most one high", kdone, kerr);
      end
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_strobe kdone=%0b kerr=%0b kdata=%02h required no strobe", kdone, kerr, kdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        assert (kerr === e.err) else begin
          fails++;
          $error("FAIL strobe_kind kerr=%0b kdone=%0b required kerr=%0b", kerr, kdone, e.err);
        end
        tests++;
        assert (kdata === e.data) else begin
          fails++;
          $error("FAIL kdata got %02h required %02h", kdata, e.data);
        end
        if (kdone && !e.err) begin
          tests++;
          assert ((cyc - stop_cyc) == FILTER + 3) else begin
            fails++;
            $error("FAIL kdone_latency got %0d required %0d", cyc - stop_cyc, FILTER + 3);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic push_ok(input logic [7:0] b);
    exp_q.push_back('{err: 1'b0, data: b});
    model_kdata = b;
  endtask

  task automatic push_err();
    exp_q.push_back('{err: 1'b1, data: model_kdata});
  endtask

  // One bit: data set while clock high, then a low half period; optional low glitch.
  task automatic send_bit(input logic b, input int half, input bit glitch, input bit is_stop);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(half / 2);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(half - half / 2 - 2);
    end else begin
      wait_cyc(half);
    end
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    wait_cyc(half);
    ps2_clk = 1'b1;
  endtask

  // Send the first nbits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int half, input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i], half, (i == glitch_bit), (i == 10));
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    wait_cyc(4);
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL %s pending=%0d required 0", tag, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    assert (kdone === 1'b0) else begin
      fails++;
      $error("FAIL %s_kdone got %0b required 0", tag, kdone);
    end
    tests++;
    assert (kerr === 1'b0) else begin
      fails++;
      $error("FAIL %s_kerr got %0b required 0", tag, kerr);
    end
    tests++;
    assert (kdata === 8'h00) else begin
      fails++;
      $error("FAIL %s_kdata got %02h required 00", tag, kdata);
    end
  endtask

  initial begin
    // Power-on reset.
    reset = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(1);
    check_reset_outputs("reset");

    // Low glitches on an idle line must be ignored.
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    drain("idle_glitch");

    // Slow frame 0x1C at an 80 us PS/2 clock.
    push_ok(8'h1C);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, HALF_SLOW, 11, -1);
    drain("frame_1c_slow");

    // Back-to-back 0xF0, 0x1C.
    push_ok(8'hF0);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, HALF_FAST, 11, -1);
    push_ok(8'h1C);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, HALF_FAST, 11, -1);
    drain("back_to_back");

    // Stop bit 0: error, kdata unchanged.
    push_err();
    send_frame(8'h33, odd_par(8'h33), 1'b0, HALF_FAST, 11, -1);
    drain("bad_stop");

    // Wrong parity on 0x1C.
`ifdef PS2_PARITY_CHECK_EN
    push_err();
`else
    push_ok(8'h1C);
`endif
    send_frame(8'h1C, 1'b1, 1'b1, HALF_FAST, 11, -1);
    drain("bad_parity");

    // Start plus 4 data bits, then silence past the timeout.
    push_err();
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, HALF_FAST, 5, -1);
    wait_cyc(TIMEOUT + 10);
    drain("timeout");
    push_ok(8'h5A);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, HALF_FAST, 11, -1);
    drain("after_timeout");

    // Mid-frame clock glitch, then a clean frame.
    push_ok(8'h21);
    send_frame(8'h21, odd_par(8'h21), 1'b1, HALF_FAST, 11, 3);
    drain("midframe_glitch");
    push_ok(8'h29);
    send_frame(8'h29, odd_par(8'h29), 1'b1, HALF_FAST, 11, -1);
    drain("after_glitch");

    // Reset after the 5th data bit of 0x1C; partial frame is abandoned.
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, HALF_FAST, 6, -1);
    wait_cyc(10);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    model_kdata = 8'h00;
    check_reset_outputs("midframe_reset");
    wait_cyc(20);
    drain("reset_no_strobe");
    push_ok(8'h32);
    send_frame(8'h32, odd_par(8'h32), 1'b1, HALF_FAST, 11, -1);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
PS/2 device-to-host receiver that feeds the I/O block's keyboard inputs (kdone/kdata).
- Synchronises and de-glitches the raw ps2_clk/ps2_data pins.
- Deserialises 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
- Emits each received scan-code byte with a one-cycle strobe. The I/O block latches the byte and raises the keyboard interrupt.

Parameters:
FILTER, 4, consecutive identical samples needed before the filtered ps2_clk changes level (range 1..15).
TIMEOUT, 25000, system clocks allowed between falling edges inside a frame before the frame is aborted (1 ms at 25 MHz).

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
ps2_data  input  1  raw PS/2 data pin, asynchronous.
kdone  output  1  one-cycle strobe: kdata holds a newly received byte.
kdata  output  8  last received scan-code byte.
kerr  output  1  one-cycle strobe: frame error (stop bit, timeout, or parity when enabled).

Behaviour:
- Reset: kdone=0, kdata=8'h00, kerr=0, state=IDLE, shift register=0, bit counter=0, timeout counter=0.
- Reset is honoured in any state, including mid-frame. The partial frame is discarded and no strobe is issued.
- Filtered clock resets to 1.
- Synchronisation: each pin passes through a 2-FF synchroniser.
- Clock filtering: the synchronised ps2_clk feeds a filter counter. The filtered clock changes level only after FILTER consecutive samples differ from its current level.
- Falling-edge strobe: high for one cycle when the filtered clock goes 1->0.
- Data sampling: ps2_data (synchronised, unfiltered) is sampled in the falling-edge cycle.
- State machine, advancing only on falling-edge cycles:
  - IDLE: sampled data 0 (start bit) -> DATA with bit counter=0. Sampled data 1 -> stay in IDLE, no error.
  - DATA: shift the sampled bit in at bit 7, shifting right, so the first bit lands in bit 0 after 8 bits. Increment the bit counter. After the 8th bit -> PARITY.
  - PARITY: store the sampled parity bit -> STOP.
  - STOP: the sampled bit decides the outcome.
    - Stop bit 1 (and parity OK when checked): in the next cycle kdata<=shift register and kdone=1 for exactly one cycle.
    - Stop bit 0: kerr=1 for one cycle and kdata unchanged.
    - In both cases -> IDLE.
- Timeout:
  - The counter clears on every falling-edge cycle and in IDLE, and increments otherwise.
  - When it reaches TIMEOUT in any non-IDLE state: kerr=1 for one cycle, then -> IDLE with the bit counter cleared.
  - A falling edge in the same cycle that the counter reaches TIMEOUT takes priority; no error is raised.
- kdone and kerr are never high in the same cycle.
- kdata is only written alongside kdone and holds its value indefinitely otherwise.
- Latency:
  - Pin falling edge to falling-edge strobe: 2 (sync) + FILTER cycles.
  - Stop-bit falling-edge strobe to kdone: 1 cycle.
- Back-to-back frames: IDLE accepts a start bit on the falling edge immediately after STOP. No minimum gap is required.
- Host-to-device transmission is out of scope. The pins are input-only.

Optional Feature:
PS2_PARITY_CHECK_EN
- Defined: the block computes odd parity over the 8 data bits plus the parity bit.
  - An even total at STOP (with stop=1) gives kerr=1 and no kdone; kdata is unchanged.
- Undefined: the parity bit is sampled and ignored. Any frame with stop=1 produces kdone.

Test Plan:
- Frame 0x1C, parity 0, stop 1, with ps2_clk period 80 us -> one kdone pulse, kdata=8'h1C, kerr never asserted.
- Frames 0xF0 then 0x1C back-to-back (parity 1, 0) -> two kdone pulses, kdata=8'hF0 then 8'h1C.
- Frame 0x1C with parity bit 1:
  - PS2_PARITY_CHECK_EN defined -> kerr pulse, no kdone, kdata keeps its previous value.
  - Undefined -> kdone with kdata=8'h1C.
- Start bit plus 4 data bits, then the clock held high for TIMEOUT+10 cycles -> exactly one kerr pulse. A following full frame 0x5A (parity 1) -> kdone with kdata=8'h5A.
- With FILTER=4, 2-cycle low glitches on ps2_clk during an idle line and mid-frame -> no state change, no strobes. The next valid frame is received correctly.
- Reset asserted for 1 cycle after the 5th data bit of frame 0x1C -> all outputs at reset values, no kdone/kerr. A following frame 0x32 (parity 0) -> kdata=8'h32.
